serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- UART receiver, 8N1, LSB first. It is the receive-side counterpart to the board's serial transmitter.
- Samples the FTDI TxD-to-FPGA line (FTDI_BD0) in the 12 MHz clock domain.
- Delivers each received byte with a one-cycle ready strobe, for command/control paths such as host-set generator selector or capture trigger.
- Detects bad stop bits (framing errors) and rejects start-bit glitches.

Parameters:
- CLKS_PER_BIT, 12, clk12 cycles per serial bit (12 = 1 Mbaud at 12 MHz). Must be at least 4.
- HALF_BIT, CLKS_PER_BIT/2, offset from the falling edge to mid-bit. Derived; do not override.

Ports:
- clk12  input  1  system clock, 12 MHz
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk12
- rbyte  output  8  last correctly received byte
- rbyte_ready  output  1  one-cycle pulse when rbyte updates
- framing_err  output  1  one-cycle pulse on a bad stop bit
- busy  output  1  high while a frame is in progress (state not IDLE)

Behaviour:
- Interface (already decided): one clock, clk12. Reset is asynchronous and active-high on reset.
- Reset values:
  - rbyte = 8'h00, rbyte_ready = 0, framing_err = 0, busy = 0.
  - Synchronizer flops = 1, state = IDLE, counters = 0.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Counters:
  - bit_cnt counts 0..CLKS_PER_BIT-1.
  - bit_idx counts 0..7.
  - shift register is 8 bits; each new bit enters at the MSB and shifts right, so the first bit received ends up at bit 0.
- IDLE:
  - rx_s==0 -> START, bit_cnt=0.
- START:
  - bit_cnt increments each cycle.
  - At bit_cnt==HALF_BIT-1, rx_s is sampled:
    - rx_s==0 -> DATA, bit_cnt=0, bit_idx=0.
    - rx_s==1 -> IDLE (glitch rejected; no strobe).
- DATA:
  - At bit_cnt==CLKS_PER_BIT-1, the bit is sampled into the shift register and bit_cnt resets to 0.
  - When bit_idx==7 is sampled -> STOP; otherwise bit_idx increments.
- STOP:
  - At bit_cnt==CLKS_PER_BIT-1, rx_s is sampled:
    - 1 -> rbyte <= shift register, rbyte_ready=1 for exactly one cycle, -> IDLE.
    - 0 -> framing_err=1 for exactly one cycle, rbyte unchanged, -> WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s==1, then -> IDLE.
  - A held-low (break) line produces exactly one framing_err and never a spurious start.
- Back-to-back frames: IDLE is entered at mid-stop-bit, so a start bit arriving immediately after the stop bit is caught. No inter-frame gap is required.
- Latency: rbyte_ready pulses 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the rx falling edge of the start bit. With defaults: 116 ±1 cycles.
- rbyte_ready and framing_err are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded, with no strobe.
- No input handshake: the consumer must capture rbyte on rbyte_ready. rbyte holds its value until the next good frame.

Optional Feature:
- Macro: SERIAL_RX_MAJORITY_EN
- Defined:
  - Every sample (start check, data bits, stop bit) is the 2-of-3 majority of rx_s taken at the nominal sample point -2, -1 and 0 cycles.
  - The decision is still made at the nominal cycle, so latency is unchanged.
  - A single-cycle glitch at mid-bit does not corrupt the bit.
- Undefined:
  - Single sample at the nominal point.
  - No extra flops for the history.

Test Plan:
- Reset, then send 0x55 at CLKS_PER_BIT=12 -> one rbyte_ready pulse, rbyte=0x55, framing_err never high, busy low afterwards.
- Send 0xA3, 0x00 and 0xFF back-to-back with no idle gap -> three rbyte_ready pulses in order with rbyte 0xA3, 0x00, 0xFF, each 120 cycles apart.
- Drive rx low for 3 cycles, then high -> no rbyte_ready, no framing_err, busy returns to 0 within HALF_BIT+3 cycles, rbyte unchanged.
- Send 0x3C with the stop bit driven 0, then hold rx low for 50 cycles -> exactly one framing_err, rbyte keeps its previous value. A following 0x81 is received correctly.
- Assert reset during bit 4 of 0x96 -> all outputs return to reset values. After release, 0x5A is received correctly.
- With SERIAL_RX_MAJORITY_EN defined: inject a 1-cycle inverted glitch at the mid-point of every data bit of 0xC5 -> rbyte=0xC5. Without the macro, the same stimulus yields 0x3A (all bits inverted).

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with a two-flop synchronizer, start-glitch rejection and framing-error detection.
// Define SERIAL_RX_MAJORITY_EN to make every sample a 2-of-3 majority vote.
`timescale 1ns/1ps
module serial_rx #(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rbyte,
    output logic       rbyte_ready,
    output logic       framing_err,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s, smp;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n, rbyte_n;
    logic          ready_n, ferr_n;

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef SERIAL_RX_MAJORITY_EN
    // rx_d1/rx_d2 are rx_s one and two cycles before the nominal sample point
    logic rx_d1, rx_d2;
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end
    assign smp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign smp = rx_s;
`endif

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rbyte       <= '0;
            rbyte_ready <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            rbyte       <= rbyte_n;
            rbyte_ready <= ready_n;
            framing_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        rbyte_n   = rbyte;
        ready_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (bit_cnt == MID) begin
                bit_cnt_n = '0;
                bit_idx_n = '0;
                state_n   = smp ? IDLE : DATA;
            end
            DATA: if (bit_cnt == LAST) begin
                bit_cnt_n = '0;
                shreg_n   = {smp, shreg[7:1]};
                bit_idx_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            // Returning to IDLE at mid-stop-bit lets an immediately following start bit be caught
            STOP: if (bit_cnt == LAST) begin
                bit_cnt_n = '0;
                rbyte_n   = smp ? shreg : rbyte;
                ready_n   = smp;
                ferr_n    = !smp;
                state_n   = smp ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                bit_cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed self-checking bench for serial_rx at CLKS_PER_BIT = 12.
`timescale 1ns/1ps
module tb_serial_rx;
    logic       clk12 = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rbyte;
    logic       rbyte_ready, framing_err, busy;

    int checks = 0, errors = 0, cyc = 0, ferr_cnt = 0, both_cnt = 0, t0 = 0;
    logic [7:0] rq[$];
    int         tq[$];

    serial_rx #(.CLKS_PER_BIT(12)) dut (
        .clk12(clk12), .reset(reset), .rx(rx), .rbyte(rbyte),
        .rbyte_ready(rbyte_ready), .framing_err(framing_err), .busy(busy)
    );

    always #5 clk12 = ~clk12;
    always @(posedge clk12) cyc <= cyc + 1;

    always @(negedge clk12) begin
        if (rbyte_ready) begin
            rq.push_back(rbyte);
            tq.push_back(cyc);
        end
        if (framing_err) ferr_cnt++;
        if (rbyte_ready && framing_err) both_cnt++;
    end

    task automatic drive(input logic v);
        @(posedge clk12);
        #1 rx = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // Drives the first ncyc cycles of a frame; glitch inverts rx at the centre of each data bit
    task automatic send(input logic [7:0] d, input logic stop, input logic glitch, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int b, o;
            logic v;
            b = i / 12;
            o = i % 12;
            v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            if (glitch && b >= 1 && b <= 8 && o == 6) v = ~v;
            drive(v);
            if (i == 0) t0 = cyc;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk12);
        #1;
        checks += 4;
        if (rbyte !== 8'h00) begin errors++; $display("FAIL reset_rbyte: got %h expected 00", rbyte); end
        if (rbyte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rbyte_ready); end
        if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_single;
        rq.delete(); tq.delete(); ferr_cnt = 0;
        send(8'h55, 1'b1, 1'b0, 120);
        idle(4);
        checks += 3;
        if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        if (rq.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rq.size()); end
        else begin
            checks += 2;
            if (rq[0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", rq[0]); end
            if (tq[0] - t0 < 115 || tq[0] - t0 > 117) begin errors++; $display("FAIL single_latency: got %0d expected 115..117", tq[0] - t0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [3];
        exp = '{8'hA3, 8'h00, 8'hFF};
        rq.delete(); tq.delete();
        for (int k = 0; k < 3; k++) send(exp[k], 1'b1, 1'b0, 120);
        idle(4);
        checks++;
        if (rq.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", rq.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rq[k] !== exp[k]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, rq[k], exp[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (tq[k] - tq[k-1] !== 120) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 120", k, tq[k] - tq[k-1]); end
            end
        end
    endtask

    task automatic test_glitch;
        rq.delete(); ferr_cnt = 0;
        repeat (3) drive(1'b0);
        idle(9);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        if (rq.size() !== 0) begin errors++; $display("FAIL glitch_ready: got %0d pulses expected 0", rq.size()); end
        if (ferr_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); end
        if (rbyte !== 8'hFF) begin errors++; $display("FAIL glitch_rbyte: got %h expected ff", rbyte); end
    endtask

    task automatic test_framing;
        rq.delete(); ferr_cnt = 0;
        send(8'h3C, 1'b0, 1'b0, 120);
        repeat (50) drive(1'b0);
        idle(20);
        checks += 4;
        if (ferr_cnt !== 1) begin errors++; $display("FAIL framing_count: got %0d expected 1", ferr_cnt); end
        if (rq.size() !== 0) begin errors++; $display("FAIL framing_ready: got %0d pulses expected 0", rq.size()); end
        if (rbyte !== 8'hFF) begin errors++; $display("FAIL framing_rbyte: got %h expected ff", rbyte); end
        if (busy !== 1'b0) begin errors++; $display("FAIL framing_busy: got %b expected 0", busy); end
        send(8'h81, 1'b1, 1'b0, 120);
        idle(4);
        checks++;
        if (rq.size() !== 1 || rbyte !== 8'h81) begin errors++; $display("FAIL framing_next: got %0d pulses rbyte %h expected 1 pulse rbyte 81", rq.size(), rbyte); end
    endtask

    task automatic test_mid_reset;
        rq.delete(); ferr_cnt = 0;
        send(8'h96, 1'b1, 1'b0, 66);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (rbyte !== 8'h00) begin errors++; $display("FAIL midrst_rbyte: got %h expected 00", rbyte); end
        if (rbyte_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", rbyte_ready); end
        if (framing_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b expected 0", framing_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        idle(3);
        @(posedge clk12);
        #1 reset = 1'b0;
        idle(12);
        checks++;
        if (rq.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL midrst_strobe: got %0d ready %0d ferr expected 0 0", rq.size(), ferr_cnt); end
        send(8'h5A, 1'b1, 1'b0, 120);
        idle(4);
        checks++;
        if (rq.size() !== 1 || rbyte !== 8'h5A) begin errors++; $display("FAIL midrst_next: got %0d pulses rbyte %h expected 1 pulse rbyte 5a", rq.size(), rbyte); end
    endtask

    task automatic test_majority_glitch;
        logic [7:0] exp;
`ifdef SERIAL_RX_MAJORITY_EN
        exp = 8'hC5;
`else
        exp = 8'h3A;
`endif
        rq.delete();
        send(8'hC5, 1'b1, 1'b1, 120);
        idle(4);
        checks++;
        if (rq.size() !== 1 || rbyte !== exp) begin errors++; $display("FAIL glitch_data: got %0d pulses rbyte %h expected 1 pulse rbyte %h", rq.size(), rbyte, exp); end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL ready_ferr_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_mid_reset();
        test_majority_glitch();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
